// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 unsigned multiply sequenced over one shared, pipelined
// 16x16 multiplier cell. Partial products are issued one per cycle and summed
// as they return, matched to their position by a tag carried alongside the
// multiplier pipeline.
// Optional feature macro: MUL_SEQ_HIGH_EN. When defined, the HH product is
// also issued and the full 64-bit product is produced (result_hi). When
// undefined, only the low 32 bits are computed and result_hi is 0.
module mul_seq_ctrl #(
    parameter int MUL_LATENCY = 1    // multiplier cell latency, 1..4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] result_hi,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p
);

`ifdef MUL_SEQ_HIGH_EN
    localparam int N     = 4;
    localparam int ACC_W = 64;
`else
    localparam int N     = 3;
    localparam int ACC_W = 32;
`endif
    localparam logic [1:0] LAST_K = 2'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t                        state, state_nxt;
    logic [31:0]                   op_a, op_b;
    logic [1:0]                    k, k_nxt;
    logic [15:0]                   sel_a, sel_b;
    logic [MUL_LATENCY-1:0]        vld_pipe;
    logic [MUL_LATENCY-1:0][1:0]   tag_pipe;
    logic                          accept, issuing, more_pending, ret_vld, fin;
    logic [1:0]                    ret_tag;
    logic [ACC_W-1:0]              acc, addend, acc_sum;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and control outputs; FINISH accepts a new start so
    // back-to-back requests lose no cycle.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mul_en    = 1'b0;
        issuing   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                mul_en  = 1'b1;
                issuing = 1'b1;
                if (k == LAST_K) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                mul_en = 1'b1;
                if (!more_pending) state_nxt = FINISH;
            end
            FINISH: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any tag still behind the output stage means more products to come;
    // the output stage itself is consumed in the current cycle.
    always_comb begin
        more_pending = 1'b0;
        for (int i = 0; i < MUL_LATENCY - 1; i++)
            more_pending = more_pending | vld_pipe[i];
    end

    assign ret_vld = mul_en & vld_pipe[MUL_LATENCY-1];
    assign ret_tag = tag_pipe[MUL_LATENCY-1];
    assign fin     = (state == DRAIN) && !more_pending;

    // Operand halves for the next issue index: k[1] picks A half, k[0] B half.
    always_comb begin
        k_nxt = k + 2'd1;
        sel_a = k_nxt[1] ? op_a[31:16] : op_a[15:0];
        sel_b = k_nxt[0] ? op_b[31:16] : op_b[15:0];
    end

    // Align the returning product by its tag before summing.
    always_comb begin
        addend = '0;
        if (ret_vld) begin
            case (ret_tag)
                2'd0:       addend = ACC_W'(mul_p);
                2'd1, 2'd2: addend = ACC_W'({mul_p, 16'h0000});
`ifdef MUL_SEQ_HIGH_EN
                2'd3:       addend = {mul_p, 32'h0000_0000};
`endif
                default:    addend = '0;
            endcase
        end
    end

    assign acc_sum = acc + addend;

    // Tag/valid pipeline shadows the multiplier and moves only when it does.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (mul_en) begin
            vld_pipe[0] <= issuing;
            tag_pipe[0] <= k;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Operand latch, issue index, multiplier operands and accumulator.
    // The first (LL) operands are loaded on accept so they are on mul_a/mul_b
    // in the first ISSUE cycle; after the last issue they simply hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            k     <= '0;
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
        end else if (accept) begin
            op_a  <= src1;
            op_b  <= src2;
            k     <= '0;
            mul_a <= src1[15:0];
            mul_b <= src2[15:0];
            acc   <= '0;
        end else begin
            if (issuing && (k != LAST_K)) begin
                k     <= k_nxt;
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
            if (ret_vld) acc <= acc_sum;
        end
    end

    // Final sum is captured together with the last product so it is visible
    // exactly in the done cycle and held until the next one.
    always_ff @(posedge clk) begin
        if (reset)    result <= '0;
        else if (fin) result <= acc_sum[31:0];
    end

`ifdef MUL_SEQ_HIGH_EN
    // High word, captured alongside the low word.
    always_ff @(posedge clk) begin
        if (reset)    result_hi <= '0;
        else if (fin) result_hi <= acc_sum[63:32];
    end
`else
    assign result_hi = '0;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: two instances (MUL_LATENCY 1 and 3),
// each driven by a behavioural pipelined multiplier model.
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_HIGH_EN
    localparam int NN = 4;
`else
    localparam int NN = 3;
`endif

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start, busy, done, mul_en;
    logic [31:0] src1 [2];
    logic [31:0] src2 [2];
    logic [31:0] result [2];
    logic [31:0] result_hi [2];
    logic [15:0] mul_a [2];
    logic [15:0] mul_b [2];
    logic [31:0] mul_p [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_ctrl #(.MUL_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .src1(src1[0]), .src2(src2[0]),
        .busy(busy[0]), .done(done[0]), .result(result[0]), .result_hi(result_hi[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]), .mul_p(mul_p[0]));

    mul_seq_ctrl #(.MUL_LATENCY(3)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .src1(src1[1]), .src2(src2[1]),
        .busy(busy[1]), .done(done[1]), .result(result[1]), .result_hi(result_hi[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]), .mul_p(mul_p[1]));

    // Multiplier cell model: product appears LAT enabled cycles after issue.
    for (genvar g = 0; g < 2; g++) begin : g_mul
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pp [LAT];
        always @(posedge clk) begin
            if (mul_en[g]) begin
                pp[0] <= {16'h0, mul_a[g]} * {16'h0, mul_b[g]};
                for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
            end
        end
        assign mul_p[g] = pp[LAT-1];
    end

    function automatic logic [31:0] hi_of(input logic [63:0] p);
`ifdef MUL_SEQ_HIGH_EN
        return p[63:32];
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pulse start for one cycle; optionally record the expected completion.
    task automatic issue(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input bit push);
        exp_t e;
        start[g] = 1'b1;
        src1[g]  = a;
        src2[g]  = b;
        e.prod   = p;
        e.cyc    = cyc + NN + ((g == 0) ? 1 : 3) + 1;
        if (push) begin
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        while (done[g] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done seen before timeout", {63'h0, done[g]}, 64'h1);
    endtask

    // Monitors: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done[0] === 1'b1) begin
            if (q0.size() == 0) chk("u0 unexpected done", 64'h1, 64'h0);
            else begin
                e0 = q0.pop_front();
                chk("u0 result", {32'h0, result[0]}, {32'h0, e0.prod[31:0]});
                chk("u0 result_hi", {32'h0, result_hi[0]}, {32'h0, hi_of(e0.prod)});
                chk("u0 done cycle", 64'(cyc), 64'(e0.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done[1] === 1'b1) begin
            if (q1.size() == 0) chk("u1 unexpected done", 64'h1, 64'h0);
            else begin
                e1 = q1.pop_front();
                chk("u1 result", {32'h0, result[1]}, {32'h0, e1.prod[31:0]});
                chk("u1 result_hi", {32'h0, result_hi[1]}, {32'h0, hi_of(e1.prod)});
                chk("u1 done cycle", 64'(cyc), 64'(e1.cyc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1;
        start = '0;
        for (int g = 0; g < 2; g++) begin
            src1[g] = '0;
            src2[g] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state of both instances
        for (int g = 0; g < 2; g++) begin
            chk("rst busy",      {63'h0, busy[g]},   64'h0);
            chk("rst done",      {63'h0, done[g]},   64'h0);
            chk("rst mul_en",    {63'h0, mul_en[g]}, 64'h0);
            chk("rst result",    {32'h0, result[g]}, 64'h0);
            chk("rst result_hi", {32'h0, result_hi[g]}, 64'h0);
            chk("rst mul_a",     {48'h0, mul_a[g]},  64'h0);
            chk("rst mul_b",     {48'h0, mul_b[g]},  64'h0);
        end
        reset = 1'b0;
        @(negedge clk);

        // 3*5 on latency 1: busy exactly T+1..T+NN+1, done right after
        issue(0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        for (int i = 1; i <= NN + 1; i++) begin
            chk("u0 busy during op", {63'h0, busy[0]}, 64'h1);
            @(negedge clk);
        end
        chk("u0 busy in done cycle", {63'h0, busy[0]}, 64'h0);
        chk("u0 done after busy",    {63'h0, done[0]}, 64'h1);
        @(negedge clk);

        // All-ones operands
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_done(0);
        @(negedge clk);

        // Product lands entirely in the high word
        issue(0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        wait_done(0);
        @(negedge clk);

        // Latency 3: mul_en window and ignored starts while busy
        t = cyc;
        chk("u1 mul_en before start", {63'h0, mul_en[1]}, 64'h0);
        issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 1'b1);
        for (int i = 1; i <= NN + 3; i++) begin
            chk("u1 mul_en during op", {63'h0, mul_en[1]}, 64'h1);
            start[1] = (i == 2 || i == 4);
            src1[1]  = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        start[1] = 1'b0;
        chk("u1 done cycle offset", 64'(cyc - t), 64'(NN + 4));
        chk("u1 mul_en in done cycle", {63'h0, mul_en[1]}, 64'h0);
        repeat (2) @(negedge clk);
        chk("u1 result held", {32'h0, result[1]}, 64'h242D_2080);
        chk("u1 idle after op", {63'h0, busy[1]}, 64'h0);

        // Back-to-back: second start in the done cycle of the first
        issue(0, 32'd2, 32'd3, 64'd6, 1'b1);
        wait_done(0);
        issue(0, 32'd7, 32'd9, 64'd63, 1'b1);
        wait_done(0);
        @(negedge clk);

        // Reset in the middle of an operation discards it
        issue(0, 32'd100, 32'd200, 64'd20000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort busy",   {63'h0, busy[0]},   64'h0);
        chk("abort done",   {63'h0, done[0]},   64'h0);
        chk("abort mul_en", {63'h0, mul_en[0]}, 64'h0);
        chk("abort result", {32'h0, result[0]}, 64'h0);
        chk("abort u1 result", {32'h0, result[1]}, 64'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(0, 32'd2, 32'd2, 64'd4, 1'b1);
        wait_done(0);

        repeat (8) @(negedge clk);
        chk("u0 queue drained", 64'(q0.size()), 64'h0);
        chk("u1 queue drained", 64'(q1.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that computes a 32x32 unsigned product using one shared, pipelined 16x16 unsigned multiplier cell.
- Splits operands into halves, issues one partial product per cycle, and accumulates the returned products into the 32-bit low result (64-bit with the optional feature).
- Sits between the CPU execute-stage request logic and the dedicated multiplier block; owns the multiplier's operand muxing and clock enable.

Parameters:
- MUL_LATENCY, 1, cycles from operands presented (with mul_en high) to product valid on mul_p; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- src1  in  32  operand A, sampled on the accepted start.
- src2  in  32  operand B, sampled on the accepted start.
- busy  out  1  high from the cycle after accept until the cycle done asserts (exclusive).
- done  out  1  one-cycle pulse; result/result_hi valid.
- result  out  32  low 32 bits of src1*src2; held until the next done.
- result_hi  out  32  high 32 bits (optional feature; otherwise constant 0).
- mul_a  out  16  multiplier operand A half.
- mul_b  out  16  multiplier operand B half.
- mul_en  out  1  multiplier pipeline enable.
- mul_p  in  32  multiplier product, MUL_LATENCY cycles after issue.

Behaviour:
- Reset: busy=0, done=0, result=0, result_hi=0, mul_a=0, mul_b=0, mul_en=0, state=IDLE, pending-tag pipeline cleared, accumulator=0.
- States: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: on start=1, latch src1/src2 into A/B, clear accumulator, go to ISSUE with issue index k=0. start while busy=1 is ignored with no side effects.
  - ISSUE: one product per cycle, N=3 products (N=4 with the feature). Order: k0=A[15:0]*B[15:0] (LL), k1=A[15:0]*B[31:16] (LH), k2=A[31:16]*B[15:0] (HL), k3=A[31:16]*B[31:16] (HH, feature only). After the last issue, go to DRAIN.
  - DRAIN: wait until all tags have returned, then go to FINISH.
  - FINISH: register the final sum, assert done for 1 cycle, return to IDLE.
- Tagging: each issue pushes its index into a MUL_LATENCY-deep tag/valid shift register advanced while mul_en=1. When the tag emerges, mul_p is accumulated:
  - LL: acc += p.
  - LH and HL: acc += p<<16.
  - HH: acc += p<<32.
  - acc is 64 bits internally; the low path is truncated to 32 bits when the feature is off.
- mul_en = 1 in every ISSUE and DRAIN cycle, 0 otherwise. mul_a/mul_b hold their last value when not issuing.
- Latency: start accepted in cycle T; issues in T+1..T+N; last product captured at T+N+MUL_LATENCY; done in cycle T+N+MUL_LATENCY+1. With defaults and no feature, done is at T+5.
- busy drops in the done cycle. A start coinciding with done is accepted, so back-to-back issue has zero bubble.
- result/result_hi update only in the done cycle and are stable otherwise.
- Reset asserted mid-operation: abort immediately, return to the reset values above; in-flight products are discarded. The first start after reset release is accepted normally.
- Overflow beyond 64 bits is impossible. The low result wraps modulo 2^32.

Optional Feature:
- Macro: MUL_SEQ_HIGH_EN.
- Defined: N=4, HH product issued, 64-bit accumulation, result_hi = high 32 bits; done at T+4+MUL_LATENCY+1.
- Undefined: N=3, no HH issue, accumulator logic limited to 32 bits, result_hi tied to 0.

Test Plan:
- src1=3, src2=5, default params -> done exactly 5 cycles after the start cycle; result=0x0000000F; busy high for cycles T+1..T+4.
- src1=0xFFFFFFFF, src2=0xFFFFFFFF, feature on -> result=0x00000001, result_hi=0xFFFFFFFE; done at T+6.
- src1=0x00010000, src2=0x00010000 -> result=0x00000000; with feature on, result_hi=0x00000001.
- MUL_LATENCY=3, src1=0x12345678, src2=0x9ABCDEF0 -> result=0x242D2080 at T+7; mul_en high exactly in T+1..T+6; start pulses during busy are ignored and result is unchanged.
- Back-to-back: a second start (7*9) asserted in the done cycle of the first operation -> second done 5 cycles later with result=0x0000003F; no lost request.
- Reset asserted at T+2 of an operation -> next cycle busy=0, done=0, result=0, mul_en=0; no done pulse occurs; a new start (2*2) completes with result=4.
